y86_fetch_unit: RTL and testbench
=================================

Name: y86_fetch_unit

Overview:
Fetch stage for the Y86-64 SEQ processor and the producer side of the decode/write-back register file.
- Fetches instruction bytes one at a time from a byte-wide instruction memory over a req/ack handshake.
- Assembles icode/ifun, rA/rB and the little-endian valC, and computes valP.
- Presents one decoded instruction per valid/ready transfer to decode.
- The next PC is returned by the later stages at hand-off time.

Parameters:
RESET_PC, 64'h0, PC loaded on reset.
ADDR_W, 64, instruction address width.

Ports:
clock  in  1  system clock, all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
mem_req  out  1  byte read request to instruction memory.
mem_addr  out  ADDR_W  byte address, stable while mem_req high.
mem_ack  in  1  memory returns mem_rdata this cycle.
mem_rdata  in  8  instruction byte.
out_valid  out  1  decoded instruction available.
out_ready  in  1  decode accepts instruction.
icode  out  4  instruction code.
ifun  out  4  function code.
rA  out  4  register A (4'hF if absent).
rB  out  4  register B (4'hF if absent).
valC  out  64  constant (0 if absent).
valP  out  ADDR_W  address of next sequential instruction.
instr_invalid  out  1  icode > 4'hB.
pc_load  in  1  use pc_new instead of valP at hand-off.
pc_new  in  ADDR_W  branch/call/ret target.
halted  out  1  fetch stopped after halt or invalid instruction.

Behaviour:
- Reset, asynchronous and immediate:
  - state=F_OP, pc=RESET_PC, mem_req=0.
  - out_valid=0, icode=ifun=0, rA=rB=4'hF, valC=0, valP=0.
  - instr_invalid=0, halted=0, byte counter=0.
  - Reset mid-fetch aborts the current instruction; partially captured bytes are discarded.
- States: F_OP, F_REG, F_CONST, PRESENT, HALT.
- F_OP:
  - mem_req=1, mem_addr=pc. On mem_ack, capture icode=rdata[7:4] and ifun=rdata[3:0].
  - Next state: F_REG if needs_regids; else F_CONST if needs_valC; else PRESENT.
- F_REG:
  - mem_addr=pc+1. On ack, capture rA=rdata[7:4] and rB=rdata[3:0].
  - Next state: F_CONST if needs_valC, else PRESENT.
- F_CONST:
  - mem_addr = pc + (needs_regids?2:1) + cnt.
  - On each ack, the byte goes into valC[8*cnt+:8] and cnt increments.
  - After the 8th byte (cnt==7 acked), cnt clears and the state goes to PRESENT.
- Memory handshake:
  - mem_req and mem_addr stay stable until mem_ack.
  - Ack may arrive in the same cycle as the request.
  - Best case is one byte per cycle; mem_ack while mem_req=0 is ignored.
- Length table. needs_regids for icodes 2,3,4,5,6,A,B. needs_valC for icodes 3,4,5,7,8. valP = pc + 1 + needs_regids + 8*needs_valC, so:
  - 1 byte: icodes 0, 1, 9.
  - 2 bytes: icodes 2, 6, A, B.
  - 9 bytes: icodes 7, 8.
  - 10 bytes: icodes 3, 4, 5.
- Invalid icode (C-F):
  - No further bytes are fetched; instr_invalid=1 and the state goes to PRESENT.
  - valP = pc+1 (informational).
- PRESENT:
  - out_valid=1. All outputs are stable until out_ready.
  - On the out_valid&&out_ready cycle: pc <= pc_load ? pc_new : valP, and out_valid drops next cycle.
  - pc_load is sampled only on that cycle.
  - Next state: HALT if icode==0 or instr_invalid; else F_OP with rA=rB=4'hF and valC=0 cleared.
- HALT: halted=1, mem_req=0, out_valid=0. Stays in HALT until reset.
- Arithmetic: PC additions are modulo 2^ADDR_W; wrap from all-ones to 0 is allowed with no error.
- First fetch after reset deasserts: mem_req rises in the first cycle.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants ICODE_HALT..ICODE_POPQ (0-B);
  - register ids RAX..R15 and RNONE=4'hF;
  - fetch state enum.
- One combinational sub-module y86_instr_len: icode -> needs_regids, needs_valC, invalid.
  - Shared later with the pipelined fetch stage.

Test Plan:
- Reset, then bytes 10 00 at 0x0 with ack every cycle -> first transfer icode=1, valP=1. Second transfer is halt with valP=2; halted=1 after its hand-off.
- irmovq, bytes 30 F3 EF CD AB 89 67 45 23 01 -> icode=3, rA=F, rB=3, valC=64'h0123456789ABCDEF, valP=0xA, after 10 acks.
- addq (60 12) presented with out_ready held 0 for 5 cycles -> outputs are constant throughout. On ready, pc becomes 2 and mem_addr=2 next.
- call (80 + 8 bytes 0x40) with pc_load=1, pc_new=0x40 at hand-off -> next mem_addr=0x40, not valP=9.
- Random 0-3 cycle ack delays over a 10-byte instruction -> same values as zero delay. mem_addr is stable during each wait.
- Byte 0xC0 -> instr_invalid=1, no second fetch, then halted=1. Assert reset during the 5th valC byte of an irmovq -> outputs at reset values, refetch starts at RESET_PC.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register ids and fetch states.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  // Register ids; 4'hF is the "no register" marker in rA/rB.
  localparam logic [3:0] RAX   = 4'h0;
  localparam logic [3:0] RCX   = 4'h1;
  localparam logic [3:0] RDX   = 4'h2;
  localparam logic [3:0] RBX   = 4'h3;
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RBP   = 4'h5;
  localparam logic [3:0] RSI   = 4'h6;
  localparam logic [3:0] RDI   = 4'h7;
  localparam logic [3:0] R8    = 4'h8;
  localparam logic [3:0] R9    = 4'h9;
  localparam logic [3:0] R10   = 4'hA;
  localparam logic [3:0] R11   = 4'hB;
  localparam logic [3:0] R12   = 4'hC;
  localparam logic [3:0] R13   = 4'hD;
  localparam logic [3:0] R14   = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    F_OP,
    F_REG,
    F_CONST,
    PRESENT,
    HALT
  } fetchState_e;

  // Fetch stops for good after a halt or an undecodable opcode.
  function automatic logic stopsFetch(input logic [3:0] icode, input logic invalid);
    return (icode == ICODE_HALT) || invalid;
  endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Instruction length decode: which optional fields follow the opcode byte.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic       needsRegids,
  output logic       needsValC,
  output logic       invalid
);

  // Table lookup of the register-id byte, the 8-byte constant and illegal codes.
  always_comb begin
    needsRegids = 1'b0;
    needsValC   = 1'b0;
    invalid     = 1'b0;
    case (icode)
      ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ: needsRegids = 1'b1;
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ: begin
        needsRegids = 1'b1;
        needsValC   = 1'b1;
      end
      ICODE_JXX, ICODE_CALL: needsValC = 1'b1;
      ICODE_HALT, ICODE_NOP, ICODE_RET: ;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/y86_fetch_unit.sv
// SEQ fetch stage: pulls instruction bytes one at a time and hands decoded
// instructions to decode over a valid/ready transfer.
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [63:0]       valC,
  output logic [ADDR_W-1:0] valP,
  output logic              instr_invalid,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_new,
  output logic              halted
);

  fetchState_e       state;
  logic [ADDR_W-1:0] pc;
  logic [2:0]        cnt;
  logic [3:0]        lenIcode;
  logic              needsRegids;
  logic              needsValC;
  logic              invalid;
  logic [ADDR_W-1:0] seqPc;
  logic [ADDR_W-1:0] nextPc;

  // While the opcode byte is on the bus, decode it directly; afterwards use the latched icode.
  assign lenIcode = (state == F_OP) ? mem_rdata[7:4] : icode;

  y86_instr_len uLen (
    .icode       (lenIcode),
    .needsRegids (needsRegids),
    .needsValC   (needsValC),
    .invalid     (invalid)
  );

  assign seqPc  = pc + ADDR_W'(1) + ADDR_W'(needsRegids) + (needsValC ? ADDR_W'(8) : '0);
  assign nextPc = pc_load ? pc_new : valP;

  // Fetch sequencer: byte requests, field capture and the hand-off to decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= F_OP;
      pc            <= RESET_PC;
      cnt           <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      out_valid     <= 1'b0;
      icode         <= '0;
      ifun          <= '0;
      rA            <= RNONE;
      rB            <= RNONE;
      valC          <= '0;
      valP          <= '0;
      instr_invalid <= 1'b0;
      halted        <= 1'b0;
    end else begin
      case (state)
        F_OP: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end else if (mem_ack) begin
            icode         <= mem_rdata[7:4];
            ifun          <= mem_rdata[3:0];
            instr_invalid <= invalid;
            valP          <= seqPc;
            if (needsRegids) begin
              state    <= F_REG;
              mem_addr <= pc + ADDR_W'(1);
            end else if (needsValC) begin
              state    <= F_CONST;
              mem_addr <= pc + ADDR_W'(1);
            end else begin
              state     <= PRESENT;
              mem_req   <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        F_REG: begin
          if (mem_ack) begin
            rA <= mem_rdata[7:4];
            rB <= mem_rdata[3:0];
            if (needsValC) begin
              state    <= F_CONST;
              mem_addr <= pc + ADDR_W'(2);
            end else begin
              state     <= PRESENT;
              mem_req   <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        F_CONST: begin
          if (mem_ack) begin
            valC[{cnt, 3'b000} +: 8] <= mem_rdata;
            if (cnt == 3'd7) begin
              cnt       <= '0;
              state     <= PRESENT;
              mem_req   <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              cnt      <= cnt + 3'd1;
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end
        PRESENT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            pc        <= nextPc;
            if (stopsFetch(icode, instr_invalid)) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state    <= F_OP;
              mem_req  <= 1'b1;
              mem_addr <= nextPc;
              rA       <= RNONE;
              rB       <= RNONE;
              valC     <= '0;
            end
          end
        end
        HALT: begin
          mem_req   <= 1'b0;
          out_valid <= 1'b0;
          halted    <= 1'b1;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Self-checking bench for y86_fetch_unit: byte memory responder with random
// ack delays and a field-level instruction reference model.
module tb_y86_fetch_unit;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        inv;
  } instr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        memReq;
  logic [63:0] memAddr;
  logic        memAck;
  logic [7:0]  memRdata;
  logic        outValid;
  logic        outReady;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        instrInvalid;
  logic        pcLoad;
  logic [63:0] pcNew;
  logic        halted;

  logic [7:0]  mem [0:255];
  int          testsRun   = 0;
  int          failCount  = 0;
  int          fetchCount = 0;
  int          maxDelay   = 0;

  y86_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_req       (memReq),
    .mem_addr      (memAddr),
    .mem_ack       (memAck),
    .mem_rdata     (memRdata),
    .out_valid     (outValid),
    .out_ready     (outReady),
    .icode         (icode),
    .ifun          (ifun),
    .rA            (rA),
    .rB            (rB),
    .valC          (valC),
    .valP          (valP),
    .instr_invalid (instrInvalid),
    .pc_load       (pcLoad),
    .pc_new        (pcNew),
    .halted        (halted)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference decode straight from the instruction-set length rules.
  function automatic instr_t modelDecode(input logic [63:0] pc);
    instr_t      r;
    logic [63:0] a;
    logic [7:0]  b;
    int          hasReg;
    int          hasC;
    a       = pc;
    b       = mem[a[7:0]];
    r.icode = b[7:4];
    r.ifun  = b[3:0];
    hasReg  = (r.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) ? 1 : 0;
    hasC    = (r.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) ? 1 : 0;
    r.inv   = (r.icode > 4'hB);
    r.rA    = 4'hF;
    r.rB    = 4'hF;
    r.valC  = 64'h0;
    if (hasReg == 1) begin
      a    = pc + 64'd1;
      b    = mem[a[7:0]];
      r.rA = b[7:4];
      r.rB = b[3:0];
    end
    if (hasC == 1) begin
      for (int i = 0; i < 8; i++) begin
        a = pc + 64'(1 + hasReg + i);
        b = mem[a[7:0]];
        r.valC[8*i +: 8] = b;
      end
    end
    r.valP = pc + 64'(1 + hasReg + 8 * hasC);
    return r;
  endfunction

  task automatic checkInstr(input string tag, input logic [63:0] pc);
    instr_t e;
    e = modelDecode(pc);
    checkOutput({tag, ".outValid"}, 64'(outValid), 64'h1);
    checkOutput({tag, ".memReq"}, 64'(memReq), 64'h0);
    checkOutput({tag, ".icode"}, 64'(icode), 64'(e.icode));
    checkOutput({tag, ".ifun"}, 64'(ifun), 64'(e.ifun));
    checkOutput({tag, ".rA"}, 64'(rA), 64'(e.rA));
    checkOutput({tag, ".rB"}, 64'(rB), 64'(e.rB));
    checkOutput({tag, ".valC"}, valC, e.valC);
    checkOutput({tag, ".valP"}, valP, e.valP);
    checkOutput({tag, ".invalid"}, 64'(instrInvalid), 64'(e.inv));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".memReq"}, 64'(memReq), 64'h0);
    checkOutput({tag, ".outValid"}, 64'(outValid), 64'h0);
    checkOutput({tag, ".icode"}, 64'(icode), 64'h0);
    checkOutput({tag, ".ifun"}, 64'(ifun), 64'h0);
    checkOutput({tag, ".rA"}, 64'(rA), 64'hF);
    checkOutput({tag, ".rB"}, 64'(rB), 64'hF);
    checkOutput({tag, ".valC"}, valC, 64'h0);
    checkOutput({tag, ".valP"}, valP, 64'h0);
    checkOutput({tag, ".invalid"}, 64'(instrInvalid), 64'h0);
    checkOutput({tag, ".halted"}, 64'(halted), 64'h0);
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (outValid !== 1'b1 && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (outValid !== 1'b1) begin
      testsRun++;
      failCount++;
      $error("[TB] FAIL %s.timeout: outValid observed %b required 1", tag, outValid);
    end
  endtask

  // Hand the presented instruction to decode, optionally redirecting the PC.
  task automatic applyStimulus(input logic load, input logic [63:0] target);
    pcLoad   = load;
    pcNew    = target;
    outReady = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b0;
    pcLoad   = 1'b0;
    pcNew    = {$urandom, $urandom};
  endtask

  task automatic resetAndRelease(input string tag);
    reset      = 1'b1;
    fetchCount = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput({tag, ".firstReq"}, 64'(memReq), 64'h1);
    checkOutput({tag, ".firstAddr"}, memAddr, 64'h0);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic loadIrmovq();
    logic [7:0] bytesIn [0:9];
    bytesIn = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    clearMem();
    for (int i = 0; i < 10; i++) mem[i] = bytesIn[i];
  endtask

  // Memory responder: acks each request after 0..maxDelay cycles and watches address stability.
  initial begin
    logic [63:0] reqAddr;
    int          waitLeft;
    bit          pending;
    memAck   = 1'b0;
    memRdata = 8'h00;
    pending  = 1'b0;
    waitLeft = 0;
    reqAddr  = '0;
    forever begin
      @(negedge clock);
      if (reset || memReq !== 1'b1) begin
        memAck  = 1'b0;
        pending = 1'b0;
      end else begin
        if (!pending) begin
          pending  = 1'b1;
          reqAddr  = memAddr;
          waitLeft = (maxDelay > 0) ? int'($urandom_range(maxDelay, 0)) : 0;
        end else begin
          checkOutput("memAddrStable", memAddr, reqAddr);
        end
        if (waitLeft == 0) begin
          memAck   = 1'b1;
          memRdata = mem[memAddr[7:0]];
          fetchCount++;
          pending  = 1'b0;
        end else begin
          memAck   = 1'b0;
          memRdata = 8'($urandom);
          waitLeft--;
        end
      end
    end
  end

  initial begin
    logic [63:0] pcQ [$];
    logic [63:0] genPc;
    instr_t      g;

    outReady = 1'b0;
    pcLoad   = 1'b0;
    pcNew    = '0;
    clearMem();

    // Reset state while reset is held.
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkResetState("reset");

    // nop then halt, one byte each.
    mem[0] = 8'h10;
    mem[1] = 8'h00;
    resetAndRelease("nopHalt");
    waitValid("nop");
    checkInstr("nop", 64'h0);
    checkOutput("nop.valPConst", valP, 64'h1);
    applyStimulus(1'b0, 64'h0);
    waitValid("halt");
    checkInstr("halt", 64'h1);
    checkOutput("halt.valPConst", valP, 64'h2);
    applyStimulus(1'b0, 64'h0);
    checkOutput("halt.halted", 64'(halted), 64'h1);
    checkOutput("halt.outValidLow", 64'(outValid), 64'h0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("halt.stays", 64'(halted), 64'h1);
    checkOutput("halt.noReq", 64'(memReq), 64'h0);
    checkOutput("halt.fetches", 64'(fetchCount), 64'd2);

    // irmovq with a full little-endian constant.
    loadIrmovq();
    resetAndRelease("irmovq");
    waitValid("irmovq");
    checkInstr("irmovq", 64'h0);
    checkOutput("irmovq.valCConst", valC, 64'h0123456789ABCDEF);
    checkOutput("irmovq.valPConst", valP, 64'hA);
    checkOutput("irmovq.fetches", 64'(fetchCount), 64'd10);

    // addq held by decode back-pressure, then call redirected, then wrap at the top of memory.
    clearMem();
    mem[0] = 8'h60; mem[1] = 8'h12;
    mem[2] = 8'h80; mem[3] = 8'h40;
    mem[8'h40] = 8'h10;
    mem[8'hFF] = 8'h10;
    resetAndRelease("addq");
    waitValid("addq");
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      checkInstr("addqHold", 64'h0);
    end
    applyStimulus(1'b0, 64'h0);
    checkOutput("addq.nextReq", 64'(memReq), 64'h1);
    checkOutput("addq.nextAddr", memAddr, 64'h2);
    waitValid("call");
    checkInstr("call", 64'h2);
    checkOutput("call.valCConst", valC, 64'h40);
    applyStimulus(1'b1, 64'h40);
    checkOutput("call.redirect", memAddr, 64'h40);
    waitValid("nop40");
    checkInstr("nop40", 64'h40);
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("wrap.addr", memAddr, 64'hFFFF_FFFF_FFFF_FFFF);
    waitValid("wrap");
    checkInstr("wrap", 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("wrap.valPConst", valP, 64'h0);
    applyStimulus(1'b0, 64'h0);
    checkOutput("wrap.nextAddr", memAddr, 64'h0);

    // Random programs with random ack latency.
    maxDelay = 3;
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      pcQ.delete();
      genPc = 64'h0;
      for (int k = 0; k < 8; k++) begin
        mem[genPc[7:0]] = {4'($urandom_range(11, 1)), 4'($urandom_range(15, 0))};
        g = modelDecode(genPc);
        pcQ.push_back(genPc);
        genPc = g.valP;
      end
      mem[genPc[7:0]] = 8'h00;
      pcQ.push_back(genPc);
      resetAndRelease("rand");
      foreach (pcQ[k]) begin
        waitValid("rand");
        checkInstr("rand", pcQ[k]);
        applyStimulus(1'b0, 64'h0);
      end
      checkOutput("rand.halted", 64'(halted), 64'h1);
      checkOutput("rand.fetches", 64'(fetchCount), 64'(genPc + 64'd1));
    end
    maxDelay = 0;

    // Invalid opcode stops fetch after one byte.
    clearMem();
    mem[0] = 8'hC0;
    mem[1] = 8'h30;
    resetAndRelease("invalid");
    waitValid("invalid");
    checkInstr("invalid", 64'h0);
    checkOutput("invalid.flag", 64'(instrInvalid), 64'h1);
    checkOutput("invalid.fetches", 64'(fetchCount), 64'd1);
    applyStimulus(1'b0, 64'h0);
    checkOutput("invalid.halted", 64'(halted), 64'h1);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("invalid.noMoreFetch", 64'(fetchCount), 64'd1);

    // Reset during the 5th constant byte of irmovq.
    loadIrmovq();
    resetAndRelease("midReset");
    begin
      int n;
      n = 0;
      while (!(memReq === 1'b1 && memAddr === 64'h6) && n < 50) begin
        @(posedge clock);
        #1;
        n++;
      end
      checkOutput("midReset.reachedByte6", memAddr, 64'h6);
    end
    reset = 1'b1;
    #1;
    checkResetState("midReset");
    resetAndRelease("refetch");
    waitValid("refetch");
    checkInstr("refetch", 64'h0);
    checkOutput("refetch.fetches", 64'(fetchCount), 64'd10);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
